// File: rtl/tile_8x8_if.sv
// Edge bus of the 4x4 MAC tile: step enable, skewed A/B operands in, accumulators and
// pass-through operands out.
interface tile_8x8_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
);
  logic                 enable;
  logic [WIDTH-1:0]     n_r0x, n_r1x, n_r2x, n_r3x;
  logic [WIDTH-1:0]     n_c0x, n_c1x, n_c2x, n_c3x;
  logic [ACC_WIDTH-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [ACC_WIDTH-1:0] y8, y9, y10, y11, y12, y13, y14, y15;
  logic [WIDTH-1:0]     n_r0y, n_r1y, n_r2y, n_r3y;
  logic [WIDTH-1:0]     n_c0y, n_c1y, n_c2y, n_c3y;

  modport master (
    output enable, n_r0x, n_r1x, n_r2x, n_r3x, n_c0x, n_c1x, n_c2x, n_c3x,
    input  y0, y1, y2, y3, y4, y5, y6, y7, y8, y9, y10, y11, y12, y13, y14, y15,
    input  n_r0y, n_r1y, n_r2y, n_r3y, n_c0y, n_c1y, n_c2y, n_c3y
  );

  modport slave (
    input  enable, n_r0x, n_r1x, n_r2x, n_r3x, n_c0x, n_c1x, n_c2x, n_c3x,
    output y0, y1, y2, y3, y4, y5, y6, y7, y8, y9, y10, y11, y12, y13, y14, y15,
    output n_r0y, n_r1y, n_r2y, n_r3y, n_c0y, n_c1y, n_c2y, n_c3y
  );
endinterface

// File: rtl/tile_8x8.sv
// 4x4 output-stationary systolic MAC tile: A shifts east, B shifts south, each PE
// accumulates one element of C = A*B.
module tile_8x8_pe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic [ACC_WIDTH-1:0] acc_o
);
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod;

  always_comb begin
    prod  = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (enable) begin
      a_d   = a_i;
      b_d   = b_i;
      // wraps modulo 2^ACC_WIDTH by design
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;
endmodule

module tile_8x8 #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  tile_8x8_if.slave  bus
);
  localparam int N = 4;

  logic [N-1:0][WIDTH-1:0]          west, north;
  logic [N-1:0][N-1:0][WIDTH-1:0]   a_q, b_q;     // [row][col]
  logic [N*N-1:0][ACC_WIDTH-1:0]    acc;

  assign west  = {bus.n_r3x, bus.n_r2x, bus.n_r1x, bus.n_r0x};
  assign north = {bus.n_c3x, bus.n_c2x, bus.n_c1x, bus.n_c0x};

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [WIDTH-1:0] a_in, b_in;
      if (j == 0) begin : g_aw
        assign a_in = west[i];
      end else begin : g_an
        assign a_in = a_q[i][j-1];
      end
      if (i == 0) begin : g_bn
        assign b_in = north[j];
      end else begin : g_bs
        assign b_in = b_q[i-1][j];
      end

      tile_8x8_pe #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .a_i    (a_in),
        .b_i    (b_in),
        .a_o    (a_q[i][j]),
        .b_o    (b_q[i][j]),
        .acc_o  (acc[N*i+j])
      );
    end
  end

  assign bus.y0  = acc[0];
  assign bus.y1  = acc[1];
  assign bus.y2  = acc[2];
  assign bus.y3  = acc[3];
  assign bus.y4  = acc[4];
  assign bus.y5  = acc[5];
  assign bus.y6  = acc[6];
  assign bus.y7  = acc[7];
  assign bus.y8  = acc[8];
  assign bus.y9  = acc[9];
  assign bus.y10 = acc[10];
  assign bus.y11 = acc[11];
  assign bus.y12 = acc[12];
  assign bus.y13 = acc[13];
  assign bus.y14 = acc[14];
  assign bus.y15 = acc[15];

  assign bus.n_r0y = a_q[0][N-1];
  assign bus.n_r1y = a_q[1][N-1];
  assign bus.n_r2y = a_q[2][N-1];
  assign bus.n_r3y = a_q[3][N-1];
  assign bus.n_c0y = b_q[N-1][0];
  assign bus.n_c1y = b_q[N-1][1];
  assign bus.n_c2y = b_q[N-1][2];
  assign bus.n_c3y = b_q[N-1][3];
endmodule

// File: tb/tb_tile_8x8.sv
// Drives skewed random and directed matrices into tile_8x8 and checks every output
// against a matrix-level model of which products have met in each PE.
module tb_tile_8x8;
  localparam int W  = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tile_8x8_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus ();
  tile_8x8 #(.WIDTH(W), .ACC_WIDTH(AW)) u_dut (.clk(clk), .reset(reset), .bus(bus));

  logic          en = 1'b0;
  logic [W-1:0]  ra[4], cb[4], ro[4], co[4];
  logic [AW-1:0] y[16];

  assign bus.enable = en;
  assign bus.n_r0x = ra[0];  assign bus.n_r1x = ra[1];
  assign bus.n_r2x = ra[2];  assign bus.n_r3x = ra[3];
  assign bus.n_c0x = cb[0];  assign bus.n_c1x = cb[1];
  assign bus.n_c2x = cb[2];  assign bus.n_c3x = cb[3];
  assign ro[0] = bus.n_r0y;  assign ro[1] = bus.n_r1y;
  assign ro[2] = bus.n_r2y;  assign ro[3] = bus.n_r3y;
  assign co[0] = bus.n_c0y;  assign co[1] = bus.n_c1y;
  assign co[2] = bus.n_c2y;  assign co[3] = bus.n_c3y;
  assign y[0]  = bus.y0;   assign y[1]  = bus.y1;   assign y[2]  = bus.y2;   assign y[3]  = bus.y3;
  assign y[4]  = bus.y4;   assign y[5]  = bus.y5;   assign y[6]  = bus.y6;   assign y[7]  = bus.y7;
  assign y[8]  = bus.y8;   assign y[9]  = bus.y9;   assign y[10] = bus.y10;  assign y[11] = bus.y11;
  assign y[12] = bus.y12;  assign y[13] = bus.y13;  assign y[14] = bus.y14;  assign y[15] = bus.y15;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Model: base accumulators from earlier runs plus the current run's matrices.
  logic [W-1:0]  ma[4][4], mb[4][4];
  int unsigned   base[16];
  logic [31:0]   qr[$], qc[$];
  logic [W-1:0]  exp_ro[4], exp_co[4];

  function automatic logic [AW-1:0] exp_y(input int idx, input int n);
    int unsigned s;
    int i, j;
    i = idx / 4;
    j = idx % 4;
    s = base[idx];
    for (int k = 0; k < 4; k++)
      if (i + j + k < n) s += int'(ma[i][k]) * int'(mb[k][j]);
    return s[AW-1:0];
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 16; i++) base[i] = 0;
    for (int i = 0; i < 4; i++) begin exp_ro[i] = '0; exp_co[i] = '0; end
    qr.delete();
    qc.delete();
    repeat (3) begin qr.push_back(32'd0); qc.push_back(32'd0); end
  endtask

  task automatic check_all(input string tag, input int n);
    for (int idx = 0; idx < 16; idx++)
      chk($sformatf("%s_y%0d", tag, idx), 32'(y[idx]), 32'(exp_y(idx, n)));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_r%0dy", tag, i), 32'(ro[i]), 32'(exp_ro[i]));
      chk($sformatf("%s_c%0dy", tag, i), 32'(co[i]), 32'(exp_co[i]));
    end
  endtask

  task automatic do_reset(input bit rand_in);
    if (rand_in) begin
      for (int i = 0; i < 4; i++) begin
        ra[i] = W'($urandom);
        cb[i] = W'($urandom);
      end
      en = 1'($urandom);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin ra[i] = '0; cb[i] = '0; end
    clr_model();
    for (int i = 0; i < 16; i++) begin ma[i/4][i%4] = '0; mb[i/4][i%4] = '0; end
    check_all("rst", 0);
  endtask

  task automatic stall(input int len, input int n);
    repeat (len) begin
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
        ra[i] = W'($urandom);
        cb[i] = W'($urandom);
      end
      @(posedge clk); #1;
      check_all("stall", n);
    end
  endtask

  // Feeds one skewed matrix pair over 10 enabled edges.
  task automatic run(input int stall_at, input int stall_len, input int abort_at);
    logic [31:0] er, ec;
    for (int t = 0; t < 10; t++) begin
      if (t == stall_at) stall(stall_len, t);
      for (int i = 0; i < 4; i++) begin
        ra[i] = (t - i >= 0 && t - i < 4) ? ma[i][t-i] : '0;
        cb[i] = (t - i >= 0 && t - i < 4) ? mb[t-i][i] : '0;
      end
      if (t == abort_at) begin
        en = 1'b1;
        do_reset(1'b0);
        return;
      end
      en = 1'b1;
      @(posedge clk); #1;
      qr.push_back({ra[3], ra[2], ra[1], ra[0]});
      qc.push_back({cb[3], cb[2], cb[1], cb[0]});
      er = qr.pop_front();
      ec = qc.pop_front();
      for (int i = 0; i < 4; i++) begin
        exp_ro[i] = er[8*i +: 8];
        exp_co[i] = ec[8*i +: 8];
      end
      check_all("run", t + 1);
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin ra[i] = '0; cb[i] = '0; end
    for (int idx = 0; idx < 16; idx++) base[idx] = int'(exp_y(idx, 10));
  endtask

  task automatic set_identity();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = (i == k) ? 8'd1 : 8'd0;
        mb[i][k] = W'(4 * i + k + 1);
      end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin ra[i] = '0; cb[i] = '0; end
    clr_model();
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b1);

    // single MAC
    ma[0][0] = 8'd3;
    mb[0][0] = 8'd5;
    run(-1, 0, -1);
    chk("mac_y0", 32'(y[0]), 32'd15);
    chk("mac_y5", 32'(y[5]), 32'd0);

    // identity, plain then with a 3-cycle stall at cycle 4
    for (int s = 0; s < 2; s++) begin
      do_reset(1'b1);
      set_identity();
      run(s ? 4 : -1, 3, -1);
      for (int idx = 0; idx < 16; idx++)
        chk($sformatf("ident%0d_y%0d", s, idx), 32'(y[idx]), 32'(idx + 1));
    end

    // wrap with all-255 operands
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) begin ma[i/4][i%4] = 8'hff; mb[i/4][i%4] = 8'hff; end
    run(-1, 0, -1);
    chk("wrap_y0", 32'(y[0]), 32'd63492);
    chk("wrap_y15", 32'(y[15]), 32'd63492);

    // reset mid-run, then re-feed from the start
    do_reset(1'b1);
    set_identity();
    run(-1, 0, 5);
    set_identity();
    run(-1, 0, -1);
    for (int idx = 0; idx < 16; idx++)
      chk($sformatf("midrst_y%0d", idx), 32'(y[idx]), 32'(idx + 1));

    // random matrices, random stalls, sometimes accumulating over previous runs
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0) do_reset(1'b1);
      for (int i = 0; i < 16; i++) begin
        ma[i/4][i%4] = W'($urandom);
        mb[i/4][i%4] = W'($urandom);
      end
      run($urandom_range(0, 9), $urandom_range(0, 3), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
